dsi_cmd_line_parser: RTL and testbench

//  Parametrised successor of the command-mode DSI packet front end; sits between the D-PHY/DSI

---
 rtl/dsi_cmd_line_parser.sv | 237 +++++++++++++++++++++++
 tb/tb_dsi_cmd_line_parser.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_cmd_line_parser.sv
// DSI command-mode line front end: extracts DCS memory-write lines (0x2C/0x3C),
// strips the DCS byte and re-packs pixels into aligned 32-bit words, tracks
// lines/frames, times the post-frame vblank window, decodes display on/off and
// pulses error flags on malformed traffic.
module dsi_cmd_line_parser #(
  parameter int unsigned X_RES      = 1080,
  parameter int unsigned Y_RES      = 2340,
  parameter int unsigned BPP        = 3,
  parameter logic [5:0]  DT_LONG    = 6'h39,
  parameter int unsigned VBLANK_DLY = 3000,
  parameter int unsigned VBLANK_LEN = 33
) (
  input  logic        clkrx,
  input  logic        reset,
  input  logic [23:0] rx_cmd,
  input  logic        rx_cmd_valid,
  input  logic [31:0] rx_payload,
  input  logic        rx_payload_valid,
  input  logic        rx_payload_valid_last,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [15:0] line_cnt,
  output logic        frame_done,
  output logic        vblank,
  output logic        power_off,
  output logic        err_len,
  output logic        err_no_sof,
  output logic        err_short_frame
);

  localparam int unsigned LINE_BYTES = X_RES * BPP;
  localparam int unsigned WORDS      = LINE_BYTES / 4;
  localparam int unsigned WCW        = $clog2(WORDS + 1);
  localparam int unsigned VBW        = $clog2(VBLANK_DLY + VBLANK_LEN + 1);

  localparam logic [15:0]    WC        = 16'(LINE_BYTES + 1);
  localparam logic [15:0]    Y_LAST    = 16'(Y_RES);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  localparam logic [VBW-1:0] VB_LO     = VBW'(VBLANK_DLY + 1);
  localparam logic [VBW-1:0] VB_HI     = VBW'(VBLANK_DLY + VBLANK_LEN);

  localparam logic [5:0] DT_DCS_SW    = 6'h05;
  localparam logic [7:0] DCS_WR_START = 8'h2C;
  localparam logic [7:0] DCS_WR_CONT  = 8'h3C;
  localparam logic [7:0] DCS_DISP_OFF = 8'h28;
  localparam logic [7:0] DCS_DISP_ON  = 8'h29;

  typedef enum logic [1:0] {IDLE, HDR, LINE, SKIP} state_t;

  state_t         state_q, state_d;
  logic [23:0]    hold_q, hold_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           sof_pend_q, sof_pend_d;
  logic [15:0]    line_cnt_q, line_cnt_d;
  logic [31:0]    pix_data_q, pix_data_d;
  logic           pix_valid_q, pix_valid_d;
  logic           pix_sof_q, pix_sof_d;
  logic           pix_eol_q, pix_eol_d;
  logic           pix_eof_q, pix_eof_d;
  logic           frame_done_q, frame_done_d;
  logic           power_off_q, power_off_d;
  logic           err_len_q, err_len_d;
  logic           err_no_sof_q, err_no_sof_d;
  logic           err_short_frame_q, err_short_frame_d;
  logic [VBW-1:0] vb_cnt_q, vb_cnt_d;
  logic           vblank_q, vblank_d;

  logic decode;
  logic line_go;
  logic pl_last;
  logic mid_frame;
  logic unused_vc;

  assign pl_last   = rx_payload_valid & rx_payload_valid_last;
  assign mid_frame = (line_cnt_q != '0) && (line_cnt_q < Y_LAST);
  assign unused_vc = &rx_cmd[7:6];

  // Header decode is shared: IDLE accepts headers, HDR/LINE abort on them.
  always_comb begin
    state_d           = state_q;
    hold_d            = hold_q;
    wcnt_d            = wcnt_q;
    sof_pend_d        = sof_pend_q;
    line_cnt_d        = line_cnt_q;
    power_off_d       = power_off_q;
    pix_data_d        = '0;
    pix_valid_d       = 1'b0;
    pix_sof_d         = 1'b0;
    pix_eol_d         = 1'b0;
    pix_eof_d         = 1'b0;
    frame_done_d      = 1'b0;
    err_len_d         = 1'b0;
    err_no_sof_d      = 1'b0;
    err_short_frame_d = 1'b0;
    decode            = 1'b0;
    line_go           = 1'b0;

    case (state_q)
      IDLE: decode = rx_cmd_valid;
      HDR: begin
        if (rx_cmd_valid) begin
          err_len_d = 1'b1;
          decode    = 1'b1;
        end else if (rx_payload_valid) begin
          hold_d = rx_payload[31:8];
          wcnt_d = '0;
          if (rx_payload[7:0] == DCS_WR_START) begin
            err_short_frame_d = mid_frame;
            line_cnt_d        = 16'd1;
            sof_pend_d        = 1'b1;
            line_go           = 1'b1;
          end else if ((rx_payload[7:0] == DCS_WR_CONT) && mid_frame) begin
            line_cnt_d = line_cnt_q + 16'd1;
            sof_pend_d = 1'b0;
            line_go    = 1'b1;
          end else begin
            err_no_sof_d = (rx_payload[7:0] == DCS_WR_CONT) && (line_cnt_q == '0);
          end
          if (line_go) begin
            if (pl_last) begin
              err_len_d = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d = LINE;
            end
          end else begin
            state_d = pl_last ? IDLE : SKIP;
          end
        end
      end
      LINE: begin
        if (rx_cmd_valid) begin
          err_len_d = 1'b1;
          decode    = 1'b1;
        end else if (rx_payload_valid) begin
          pix_valid_d = 1'b1;
          pix_data_d  = {rx_payload[7:0], hold_q};
          pix_sof_d   = sof_pend_q;
          sof_pend_d  = 1'b0;
          hold_d      = rx_payload[31:8];
          wcnt_d      = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            pix_eol_d = 1'b1;
            if (line_cnt_q == Y_LAST) begin
              pix_eof_d    = 1'b1;
              frame_done_d = 1'b1;
              line_cnt_d   = '0;
            end
            state_d = pl_last ? IDLE : SKIP;
          end else if (pl_last) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      SKIP: if (pl_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (decode) begin
      state_d = IDLE;
      if ((rx_cmd[5:0] == DT_LONG) && (rx_cmd[23:8] == WC)) begin
        state_d = HDR;
      end else if (rx_cmd[3:0] > 4'h8) begin
        state_d = SKIP;
      end else if (rx_cmd[5:0] == DT_DCS_SW) begin
        if (rx_cmd[15:8] == DCS_DISP_OFF) power_off_d = 1'b1;
        else if (rx_cmd[15:8] == DCS_DISP_ON) power_off_d = 1'b0;
      end
    end
  end

  // A frame_done restarts the delay+window count from 1.
  always_comb begin
    if (frame_done_q) vb_cnt_d = VBW'(1);
    else if ((vb_cnt_q == '0) || (vb_cnt_q == VB_HI)) vb_cnt_d = '0;
    else vb_cnt_d = vb_cnt_q + 1'b1;
    vblank_d = (vb_cnt_d >= VB_LO) && (vb_cnt_d <= VB_HI);
  end

  always_ff @(posedge clkrx) begin
    if (reset) begin
      state_q           <= IDLE;
      hold_q            <= '0;
      wcnt_q            <= '0;
      sof_pend_q        <= 1'b0;
      line_cnt_q        <= '0;
      pix_data_q        <= '0;
      pix_valid_q       <= 1'b0;
      pix_sof_q         <= 1'b0;
      pix_eol_q         <= 1'b0;
      pix_eof_q         <= 1'b0;
      frame_done_q      <= 1'b0;
      power_off_q       <= 1'b0;
      err_len_q         <= 1'b0;
      err_no_sof_q      <= 1'b0;
      err_short_frame_q <= 1'b0;
      vb_cnt_q          <= '0;
      vblank_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      hold_q            <= hold_d;
      wcnt_q            <= wcnt_d;
      sof_pend_q        <= sof_pend_d;
      line_cnt_q        <= line_cnt_d;
      pix_data_q        <= pix_data_d;
      pix_valid_q       <= pix_valid_d;
      pix_sof_q         <= pix_sof_d;
      pix_eol_q         <= pix_eol_d;
      pix_eof_q         <= pix_eof_d;
      frame_done_q      <= frame_done_d;
      power_off_q       <= power_off_d;
      err_len_q         <= err_len_d;
      err_no_sof_q      <= err_no_sof_d;
      err_short_frame_q <= err_short_frame_d;
      vb_cnt_q          <= vb_cnt_d;
      vblank_q          <= vblank_d;
    end
  end

  assign pix_data        = pix_data_q;
  assign pix_valid       = pix_valid_q;
  assign pix_sof         = pix_sof_q;
  assign pix_eol         = pix_eol_q;
  assign pix_eof         = pix_eof_q;
  assign line_cnt        = line_cnt_q;
  assign frame_done      = frame_done_q;
  assign vblank          = vblank_q;
  assign power_off       = power_off_q;
  assign err_len         = err_len_q;
  assign err_no_sof      = err_no_sof_q;
  assign err_short_frame = err_short_frame_q;

endmodule

// File: tb/tb_dsi_cmd_line_parser.sv
// Bench for dsi_cmd_line_parser: packet-level model schedules per-cycle
// expectations, one negedge process compares every output every cycle.
module tb_dsi_cmd_line_parser;

  localparam int unsigned X_RES  = 4;
  localparam int unsigned Y_RES  = 2;
  localparam int unsigned BPP    = 3;
  localparam int unsigned VB_DLY = 8;
  localparam int unsigned VB_LEN = 2;
  localparam int unsigned WC     = X_RES * BPP + 1;
  localparam int unsigned NPIX   = X_RES * BPP / 4;
  localparam int          NCYC   = 1024;

  logic        clkrx = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] rx_cmd = '0;
  logic        rx_cmd_valid = 1'b0;
  logic [31:0] rx_payload = '0;
  logic        rx_payload_valid = 1'b0;
  logic        rx_payload_valid_last = 1'b0;
  logic [31:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, pix_eof;
  logic [15:0] line_cnt;
  logic        frame_done, vblank, power_off;
  logic        err_len, err_no_sof, err_short_frame;

  dsi_cmd_line_parser #(
    .X_RES(X_RES), .Y_RES(Y_RES), .BPP(BPP), .DT_LONG(6'h39),
    .VBLANK_DLY(VB_DLY), .VBLANK_LEN(VB_LEN)
  ) dut (
    .clkrx(clkrx), .reset(reset),
    .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid),
    .rx_payload(rx_payload), .rx_payload_valid(rx_payload_valid),
    .rx_payload_valid_last(rx_payload_valid_last),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .pix_eof(pix_eof), .line_cnt(line_cnt),
    .frame_done(frame_done), .vblank(vblank), .power_off(power_off),
    .err_len(err_len), .err_no_sof(err_no_sof), .err_short_frame(err_short_frame)
  );

  always #5 clkrx = ~clkrx;

  int cyc = 0;
  always @(posedge clkrx) cyc <= cyc + 1;

  // Per-cycle expectations, indexed by the cycle the output is visible.
  bit          e_pv[NCYC], e_sof[NCYC], e_eol[NCYC], e_eof[NCYC], e_fd[NCYC];
  bit          e_elen[NCYC], e_nosof[NCYC], e_short[NCYC], e_rst[NCYC];
  logic [31:0] e_pd[NCYC];
  int          e_line[NCYC];
  int          e_pwr[NCYC];

  int m_line = 0;
  bit m_open = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Compare process and observation capture.
  bit          chk_en = 1'b0;
  int          cur_line = 0;
  bit          cur_pwr = 1'b0;
  int          last_fd = -1;
  logic [34:0] seen_pix[$];
  int          fd_seen_at = -1, vb_rise_at = -1, vb_hi_cnt = 0;
  int          n_nosof_seen = 0, n_short_seen = 0;
  bit          vb_prev = 1'b0;

  always @(negedge clkrx) begin
    int c;
    bit exp_vb;
    if (chk_en) begin
      c = cyc;
      if (e_rst[c]) begin
        cur_line = 0;
        cur_pwr  = 1'b0;
        last_fd  = -1;
      end
      if (e_line[c] >= 0) cur_line = e_line[c];
      if (e_pwr[c] >= 0) cur_pwr = (e_pwr[c] == 1);
      exp_vb = (last_fd >= 0) && (c - last_fd >= int'(VB_DLY) + 1) &&
               (c - last_fd <= int'(VB_DLY + VB_LEN));
      if (e_fd[c]) last_fd = c;

      chk("pix_valid", 36'(pix_valid), 36'(e_pv[c]));
      if (e_pv[c]) begin
        chk("pix_data", 36'(pix_data), 36'(e_pd[c]));
        chk("pix_sof", 36'(pix_sof), 36'(e_sof[c]));
        chk("pix_eol", 36'(pix_eol), 36'(e_eol[c]));
        chk("pix_eof", 36'(pix_eof), 36'(e_eof[c]));
      end
      chk("frame_done", 36'(frame_done), 36'(e_fd[c]));
      chk("vblank", 36'(vblank), 36'(exp_vb));
      chk("line_cnt", 36'(line_cnt), 36'(cur_line));
      chk("power_off", 36'(power_off), 36'(cur_pwr));
      chk("err_len", 36'(err_len), 36'(e_elen[c]));
      chk("err_no_sof", 36'(err_no_sof), 36'(e_nosof[c]));
      chk("err_short_frame", 36'(err_short_frame), 36'(e_short[c]));

      if (pix_valid) seen_pix.push_back({pix_sof, pix_eol, pix_eof, pix_data});
      if (frame_done) fd_seen_at = c;
      if (vblank && !vb_prev) vb_rise_at = c;
      if (vblank) vb_hi_cnt++;
      vb_prev = vblank;
      if (err_no_sof) n_nosof_seen++;
      if (err_short_frame) n_short_seen++;
    end
  end

  task automatic tick();
    @(posedge clkrx);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int len);
    int n;
    n = cyc;
    for (int i = 1; i <= len; i++) e_rst[n + i] = 1'b1;
    m_line = 0;
    m_open = 1'b0;
    reset = 1'b1;
    repeat (len) tick();
    reset = 1'b0;
  endtask

  // Long packet: header then k consecutive payload words; byte0 = dcs,
  // bytes 1..WC-1 = index+seed, padding zero. term puts valid_last on word k-1.
  task automatic send_long(input logic [23:0] cmd, input int k, input bit term,
                           input logic [7:0] dcs, input logic [7:0] seed);
    logic [7:0] by[64];
    int         n, nout;
    bit         acc, go, sof;
    n = cyc;
    for (int i = 0; i < 64; i++)
      by[i] = (i == 0) ? dcs : (i < int'(WC)) ? 8'(i) + seed : 8'h00;

    if (m_open) e_elen[n + 1] = 1'b1;
    m_open = 1'b0;
    acc = (cmd[5:0] == 6'h39) && (cmd[23:8] == 16'(WC));
    go  = 1'b0;
    sof = 1'b0;
    if (acc && k == 0 && !term) m_open = 1'b1;
    if (acc && k >= 1) begin
      if (dcs == 8'h2C) begin
        if (m_line >= 1 && m_line < int'(Y_RES)) e_short[n + 2] = 1'b1;
        m_line = 1;
        sof    = 1'b1;
        go     = 1'b1;
      end else if (dcs == 8'h3C && m_line >= 1 && m_line < int'(Y_RES)) begin
        m_line++;
        go = 1'b1;
      end else if (dcs == 8'h3C && m_line == 0) begin
        e_nosof[n + 2] = 1'b1;
      end
      if (go) begin
        e_line[n + 2] = m_line;
        nout = (k - 1 < int'(NPIX)) ? k - 1 : int'(NPIX);
        for (int j = 0; j < nout; j++) begin
          e_pv[n + j + 3]  = 1'b1;
          e_pd[n + j + 3]  = {by[4*j+4], by[4*j+3], by[4*j+2], by[4*j+1]};
          e_sof[n + j + 3] = sof && (j == 0);
        end
        if (nout == int'(NPIX)) begin
          e_eol[n + NPIX + 2] = 1'b1;
          if (m_line == int'(Y_RES)) begin
            e_eof[n + NPIX + 2]  = 1'b1;
            e_fd[n + NPIX + 2]   = 1'b1;
            e_line[n + NPIX + 2] = 0;
            m_line = 0;
          end
        end else if (term) begin
          e_elen[n + k + 1] = 1'b1;
        end else begin
          m_open = 1'b1;
        end
      end
    end

    rx_cmd = cmd;
    rx_cmd_valid = 1'b1;
    tick();
    rx_cmd_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      rx_payload = {by[4*i+3], by[4*i+2], by[4*i+1], by[4*i]};
      rx_payload_valid = 1'b1;
      rx_payload_valid_last = term && (i == k - 1);
      tick();
    end
    rx_payload_valid = 1'b0;
    rx_payload_valid_last = 1'b0;
  endtask

  task automatic send_short(input logic [23:0] cmd);
    int n;
    n = cyc;
    if (m_open) e_elen[n + 1] = 1'b1;
    m_open = 1'b0;
    if (cmd[5:0] == 6'h05) begin
      if (cmd[15:8] == 8'h28) e_pwr[n + 1] = 1;
      else if (cmd[15:8] == 8'h29) e_pwr[n + 1] = 0;
    end
    rx_cmd = cmd;
    rx_cmd_valid = 1'b1;
    tick();
    rx_cmd_valid = 1'b0;
  endtask

  initial begin
    int npix;
    for (int i = 0; i < NCYC; i++) begin
      e_line[i] = -1;
      e_pwr[i]  = -1;
    end
    tick();
    chk_en = 1'b1;
    do_reset(2);
    idle(2);

    // First 2C line of the reference vector.
    send_long(24'h000D39, 4, 1'b1, 8'h2C, 8'h00);
    idle(3);
    chk("lit_npix", 36'(seen_pix.size()), 36'd3);
    if (seen_pix.size() >= 3) begin
      chk("lit_pix0", 36'(seen_pix[0]), {1'b0, 3'b100, 32'h04030201});
      chk("lit_pix1", 36'(seen_pix[1]), {1'b0, 3'b000, 32'h08070605});
      chk("lit_pix2", 36'(seen_pix[2]), {1'b0, 3'b010, 32'h0C0B0A09});
    end
    chk("lit_line1", 36'(line_cnt), 36'd1);

    // Second line closes the frame; watch the vblank window.
    send_long(24'h000D39, 4, 1'b1, 8'h3C, 8'h10);
    idle(14);
    chk("lit_line0", 36'(line_cnt), 36'd0);
    chk("lit_vb_delay", 36'(vb_rise_at - fd_seen_at), 36'd9);
    chk("lit_vb_len", 36'(vb_hi_cnt), 36'd2);

    // Continue without a frame start.
    do_reset(2);
    npix = seen_pix.size();
    send_long(24'h000D39, 4, 1'b1, 8'h3C, 8'h20);
    idle(2);
    chk("lit_nosof", 36'(n_nosof_seen), 36'd1);
    chk("lit_nosof_nopix", 36'(seen_pix.size()), 36'(npix));

    // Restart mid-frame.
    send_long(24'h000D39, 4, 1'b1, 8'h2C, 8'h30);
    send_long(24'h000D39, 4, 1'b1, 8'h2C, 8'h40);
    idle(2);
    chk("lit_short", 36'(n_short_seen), 36'd1);
    chk("lit_short_line", 36'(line_cnt), 36'd1);

    // Truncated line, then a full continue line closes the frame.
    send_long(24'h000D39, 2, 1'b1, 8'h2C, 8'h50);
    send_long(24'h000D39, 4, 1'b1, 8'h3C, 8'h60);
    idle(3);

    // Wrong WC and wrong DT are skipped.
    npix = seen_pix.size();
    send_long(24'h000E39, 4, 1'b1, 8'h2C, 8'h70);
    send_long(24'h000D29, 4, 1'b1, 8'h2C, 8'h80);
    idle(2);
    chk("lit_skip_nopix", 36'(seen_pix.size()), 36'(npix));

    // Display off / on.
    send_short(24'h002805);
    idle(2);
    chk("lit_pwr_off", 36'(power_off), 36'd1);
    send_short(24'h002905);
    idle(2);
    chk("lit_pwr_on", 36'(power_off), 36'd0);

    // Back-to-back frames: second frame_done lands on the last window cycle.
    send_long(24'h000D39, 4, 1'b1, 8'h2C, 8'h90);
    send_long(24'h000D39, 4, 1'b1, 8'h3C, 8'hA0);
    send_long(24'h000D39, 4, 1'b1, 8'h2C, 8'hB0);
    send_long(24'h000D39, 4, 1'b1, 8'h3C, 8'hC0);
    idle(16);

    // Aborts by new headers in HDR and in LINE.
    send_long(24'h000D39, 0, 1'b0, 8'h2C, 8'h00);
    send_short(24'h002805);
    send_long(24'h000D39, 2, 1'b0, 8'h2C, 8'hD0);
    send_short(24'h002905);
    send_long(24'h000D39, 1, 1'b0, 8'h2C, 8'hE0);
    send_long(24'h000D39, 4, 1'b1, 8'h3C, 8'hF0);
    idle(3);

    // Reset mid-line with power_off set.
    send_short(24'h002805);
    send_long(24'h000D39, 2, 1'b0, 8'h2C, 8'h05);
    do_reset(1);
    chk("lit_rst_line", 36'(line_cnt), 36'd0);
    chk("lit_rst_pwr", 36'(power_off), 36'd0);
    chk("lit_rst_pv", 36'(pix_valid), 36'd0);
    idle(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
